lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 255, memory-acknowledge timeout in cycles (1..255).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  4  byte write enables.
- mem_addr  out  32  word-aligned address, bits [1:0] = 00.
- mem_wdata  out  32  lane-shifted store data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  32  read word, valid with mem_ack.
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline consumes response.
- resp_data  out  32  extracted, extended load result; 0 for stores.
- resp_err  out  1  timeout or misaligned-trap error.

Function
REQ-003 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-004 IDLE: req_ready = 1. On req_valid, SHALL latch we, funct3, addr and wdata, then go to ISSUE.
REQ-005 req_ready SHALL be 0 in every state other than IDLE, so at most one access is outstanding.
REQ-006 ISSUE: SHALL assert mem_en for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-007 WAIT: mem_ack SHALL move the FSM to RESP and capture the processed result. mem_ack SHALL be ignored in every other state.
REQ-008 WAIT: the counter SHALL increment each cycle without ack. When the count reaches MAX_WAIT, the FSM SHALL go to RESP with resp_err = 1 and resp_data = 0. If ack and the timeout coincide, ack wins.
REQ-009 RESP: resp_valid = 1, and resp_data and resp_err SHALL hold stable until resp_ready. On resp_ready the FSM SHALL go to IDLE.
REQ-010 A new request SHALL be accepted no earlier than the cycle after the response handshake. The minimum request-to-resp_valid latency is 3 cycles (accept N, mem_en N+1, ack N+2, resp_valid N+3).
REQ-011 Load extraction, with off = addr[1:0]:
- B/BU: byte rdata[8*off+7 : 8*off].
- H/HU: halfword rdata[16*addr[1]+15 : 16*addr[1]].
- Sign-extend for 000/001; zero-extend for 100/101.
- W and any other funct3: raw rdata.
REQ-012 Store lanes:
- SB: mem_we = 0001 << off, wdata byte replicated to all four lanes.
- SH: mem_we = 0011 << (2*addr[1]), halfword replicated to both halves.
- SW: mem_we = 1111.
- Any other funct3: mem_we = 0000, while the access still completes normally.
REQ-013 mem_we SHALL be 0000 whenever mem_en = 0. Loads SHALL drive mem_we = 0000.
REQ-014 Stores SHALL respond with resp_data = 0.
REQ-015 mem_addr SHALL be {addr[31:2], 2'b00}.

Reset
REQ-016 rst SHALL act asynchronously in any state, including mid-access:
- FSM returns to IDLE; counter cleared.
- mem_en = 0, mem_we = 0000, mem_addr = 0, mem_wdata = 0.
- resp_valid = 0, resp_data = 0, resp_err = 0.
- req_ready = 1 after release.
REQ-017 A mem_ack arriving after reset that belongs to an aborted access SHALL be ignored, because the FSM is no longer in WAIT.

Configuration
REQ-018 Macro LSU_MISALIGN_TRAP_EN, when defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 00, SHALL skip ISSUE/WAIT and go directly to RESP, with resp_err = 1, resp_data = 0 and no mem_en pulse.
REQ-019 When LSU_MISALIGN_TRAP_EN is undefined, misaligned accesses SHALL proceed. Low address bits are used only for lane selection per REQ-011/012, and resp_err is set only by timeout.

Verification
REQ-020 LB: addr = 0x1, ack next cycle with rdata = 0x1234_F678 -> resp_data = 0xFFFF_FFF6, resp_err = 0, resp_valid at accept+3.
REQ-021 LHU: addr = 0x2, rdata = 0x89AB_CDEF -> resp_data = 0x0000_89AB. LW with rdata = 0x8765_4321 -> resp_data = 0x8765_4321.
REQ-022 SB: addr = 0x3, wdata = 0x0000_00A5 -> single mem_en cycle, mem_we = 1000, mem_wdata = 0xA5A5_A5A5, mem_addr = 0x0, resp_data = 0.
REQ-023 Timeout with MAX_WAIT = 4 and no ack -> resp_err = 1 after exactly 4 WAIT cycles. A late ack afterwards has no effect. Hold resp_ready = 0 for 3 cycles -> resp_valid and data stay stable.
REQ-024 Assert rst during WAIT, then ack on the next cycle -> all outputs at reset values, no response. A subsequent LW completes normally.
REQ-025 With LSU_MISALIGN_TRAP_EN defined: LW at addr = 0x2 -> no mem_en, resp_err = 1, resp_data = 0. With it undefined, the same request -> mem_en pulse with mem_addr = 0x0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding access, byte-lane steering, load extension, ack timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses respond with an error, no memory strobe.
module lsu_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  cnt_reg;
  logic [31:0] data_reg;
  logic        err_reg;

  logic [1:0]  off;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [3:0]  store_we;
  logic [31:0] store_data;
  logic        timeout;
  logic        trap_hit;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    trap_hit = 1'b0;
    case (req_funct3)
      3'b001, 3'b101: trap_hit = req_addr[0];
      3'b010:         trap_hit = |req_addr[1:0];
      default:        trap_hit = 1'b0;
    endcase
  end
`else
  assign trap_hit = 1'b0;
`endif

  assign off       = addr_reg[1:0];
  assign lane_byte = mem_rdata[{off, 3'b000} +: 8];
  assign lane_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign timeout   = (cnt_reg == LAST_CNT);

  always_comb begin
    load_data = mem_rdata;
    case (funct3_reg)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Store data is replicated across lanes so the enables alone select the target bytes.
  always_comb begin
    store_we   = 4'b0000;
    store_data = wdata_reg;
    case (funct3_reg)
      3'b000: begin
        store_we   = 4'b0001 << off;
        store_data = {4{wdata_reg[7:0]}};
      end
      3'b001: begin
        store_we   = addr_reg[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_reg[15:0]}};
      end
      3'b010: store_we = 4'b1111;
      default: store_we = 4'b0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = trap_hit ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mem_ack || timeout) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req_valid) begin
          we_reg     <= req_we;
          funct3_reg <= req_funct3;
          addr_reg   <= req_addr;
          wdata_reg  <= req_wdata;
          data_reg   <= '0;
          err_reg    <= trap_hit;
        end
        ISSUE: cnt_reg <= '0;
        WAIT: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            data_reg <= we_reg ? 32'd0 : load_data;
            err_reg  <= 1'b0;
          end else if (timeout) begin
            data_reg <= '0;
            err_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign mem_en     = (state_reg == ISSUE);
  assign mem_we     = (mem_en && we_reg) ? store_we : 4'b0000;
  assign mem_addr   = {addr_reg[31:2], 2'b00};
  assign mem_wdata  = store_data;
  assign resp_valid = (state_reg == RESP);
  assign resp_data  = data_reg;
  assign resp_err   = err_reg;

endmodule
